lb_debounce_oneshot: RTL and testbench

//   Conditions one raw, asynchronous push-button/switch input for the PicoBlaze SoC.

---
 rtl/lb_debounce_oneshot_if.sv | 24 ++
 rtl/lb_debounce_oneshot.sv | 116 +++++++++++
 tb/tb_lb_debounce_oneshot.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lb_debounce_oneshot_if.sv
// Raw button input and conditioned outputs of lb_debounce_oneshot.
interface lb_debounce_oneshot_if;
  logic btn_in;
  logic db_level;
  logic db_rise;
  logic db_fall;
  logic busy;

  modport master (
    output btn_in,
    input  db_level,
    input  db_rise,
    input  db_fall,
    input  busy
  );

  modport slave (
    input  btn_in,
    output db_level,
    output db_rise,
    output db_fall,
    output busy
  );
endinterface

// File: rtl/lb_debounce_oneshot.sv
// Push-button conditioner: 2-flop synchroniser, counter-based debounce FSM,
// registered level plus single-cycle rise/fall pulses.
module lb_debounce_oneshot #(
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned DEBOUNCE_CNT = 1_000_000
) (
  input logic                   clk,
  input logic                   reset,
  lb_debounce_oneshot_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

  logic             sync0_q, sync1_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
    end else begin
      sync0_q <= bus.btn_in;
      sync1_q <= sync0_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  // busy is registered from the next state so it lines up with the WAIT states.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      IDLE_LO: begin
        if (sync1_q) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      end
      WAIT_HI: begin
        if (!sync1_q) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE_HI: begin
        if (!sync1_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (sync1_q) begin
          state_d = IDLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE_LO;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

  assign bus.db_level = level_q;
  assign bus.db_rise  = rise_q;
  assign bus.db_fall  = fall_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_lb_debounce_oneshot.sv
// Bench for lb_debounce_oneshot with DEBOUNCE_CNT=4, CNT_W=3.
// Outputs compared as {db_level, db_rise, db_fall, busy}.
module tb_lb_debounce_oneshot;

  typedef struct {
    logic       btn;
    logic [3:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs[47];

  lb_debounce_oneshot_if bus_if ();

  lb_debounce_oneshot #(
    .CNT_W        (3),
    .DEBOUNCE_CNT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] outs();
    return {bus_if.db_level, bus_if.db_rise, bus_if.db_fall, bus_if.busy};
  endfunction

  task automatic chk(input string name, input int idx, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got lvl/rise/fall/busy=%b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // After reset release with btn_in high: first posedge is edge 0,
  // busy on edges 2..5, rise + level on edge 6, rise clears on edge 7.
  task automatic check_release_rise(input string name);
    logic [3:0] e;
    for (int k = 0; k < 9; k++) begin
      tick();
      e = 4'b0000;
      if (k >= 2 && k <= 5) e = 4'b0001;
      if (k == 6) e = 4'b1100;
      if (k >= 7) e = 4'b1000;
      chk(name, k, outs(), e);
    end
  endtask

  task automatic do_reset(input logic btn);
    @(negedge clk);
    bus_if.btn_in = btn;
    reset = 1'b1;
    #1;
    chk("reset_async", 0, outs(), 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("reset_hold", k, outs(), 4'b0000);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // clean press, release, glitch, bounce-then-settle, hold
    vecs[0]  = '{1'b0, 4'b0000}; vecs[1]  = '{1'b0, 4'b0000};
    vecs[2]  = '{1'b1, 4'b0000}; vecs[3]  = '{1'b1, 4'b0000};
    vecs[4]  = '{1'b1, 4'b0001}; vecs[5]  = '{1'b1, 4'b0001};
    vecs[6]  = '{1'b1, 4'b0001}; vecs[7]  = '{1'b1, 4'b0001};
    vecs[8]  = '{1'b1, 4'b1100}; vecs[9]  = '{1'b1, 4'b1000};
    vecs[10] = '{1'b1, 4'b1000};
    vecs[11] = '{1'b0, 4'b1000}; vecs[12] = '{1'b0, 4'b1000};
    vecs[13] = '{1'b0, 4'b1001}; vecs[14] = '{1'b0, 4'b1001};
    vecs[15] = '{1'b0, 4'b1001}; vecs[16] = '{1'b0, 4'b1001};
    vecs[17] = '{1'b0, 4'b0010}; vecs[18] = '{1'b0, 4'b0000};
    vecs[19] = '{1'b0, 4'b0000};
    vecs[20] = '{1'b1, 4'b0000}; vecs[21] = '{1'b1, 4'b0000};
    vecs[22] = '{1'b1, 4'b0001}; vecs[23] = '{1'b0, 4'b0001};
    vecs[24] = '{1'b0, 4'b0001}; vecs[25] = '{1'b0, 4'b0000};
    vecs[26] = '{1'b0, 4'b0000}; vecs[27] = '{1'b0, 4'b0000};
    vecs[28] = '{1'b1, 4'b0000}; vecs[29] = '{1'b1, 4'b0000};
    vecs[30] = '{1'b0, 4'b0001}; vecs[31] = '{1'b0, 4'b0001};
    vecs[32] = '{1'b1, 4'b0000}; vecs[33] = '{1'b1, 4'b0000};
    vecs[34] = '{1'b0, 4'b0001}; vecs[35] = '{1'b0, 4'b0001};
    vecs[36] = '{1'b1, 4'b0000}; vecs[37] = '{1'b1, 4'b0000};
    vecs[38] = '{1'b1, 4'b0001}; vecs[39] = '{1'b1, 4'b0001};
    vecs[40] = '{1'b1, 4'b0001}; vecs[41] = '{1'b1, 4'b0001};
    vecs[42] = '{1'b1, 4'b1100}; vecs[43] = '{1'b1, 4'b1000};
    vecs[44] = '{1'b1, 4'b1000}; vecs[45] = '{1'b1, 4'b1000};
    vecs[46] = '{1'b1, 4'b1000};

    bus_if.btn_in = 1'b1;

    // btn_in held high through reset is a new rise after release
    do_reset(1'b1);
    check_release_rise("rise_after_reset");

    // reset with the input low, then the vector table
    do_reset(1'b0);
    for (int i = 0; i < 47; i++) begin
      @(negedge clk);
      bus_if.btn_in = vecs[i].btn;
      tick();
      chk("vec", i, outs(), vecs[i].exp);
    end

    // reset in the middle of a WAIT: busy drops at once, no pulse
    do_reset(1'b0);
    @(negedge clk);
    bus_if.btn_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("midwait_pre", k, outs(), (k >= 2) ? 4'b0001 : 4'b0000);
    end
    reset = 1'b1;
    #1;
    chk("midwait_async_clear", 0, outs(), 4'b0000);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("midwait_in_reset", k, outs(), 4'b0000);
    end
    @(negedge clk);
    reset = 1'b0;
    check_release_rise("midwait_release");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
